// File: rtl/bbc_bus_responder.sv
// bbc_bus_responder: BBC bus target with an FE30 ROM select shadow and an FC40/FC41 mailbox FIFO.
// Define MBOX_OVERFLOW_FLAG_EN to keep a sticky overflow flag in status bit 2.
module bbc_bus_responder #(
    parameter logic [15:0] ROMSEL_ADDR = 16'hFE30,
    parameter logic [15:0] MBOX_ADDR   = 16'hFC40,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          HOLD_CYCLES = 2
) (
    input  logic        hsclk,
    input  logic        reset,
    input  logic        bbc_phi2,
    input  logic [15:0] bbc_adr,
    input  logic        bbc_rnw,
    input  logic [7:0]  bbc_data_in,
    output logic [7:0]  bbc_data_out,
    output logic        bbc_data_oe,
    output logic [3:0]  romsel,
    output logic        mbox_valid,
    output logic [7:0]  mbox_data,
    input  logic        mbox_ready,
    input  logic [7:0]  reply_data
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          PW        = AW + 1;
    localparam logic [15:0] STAT_ADDR = MBOX_ADDR + 16'd1;
    localparam logic [2:0]  HOLD_LAST = 3'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        DRIVE,
        WRWAIT,
        SKIP,
        HOLD
    } state_t;

    state_t        state;
    logic          s1, s2, s3;
    logic          rise, fall;
    logic [7:0]    shadow;
    logic [15:0]   lat_adr;
    logic          lat_rnw;
    logic [2:0]    hold_cnt;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    mem [FIFO_DEPTH];
    logic          empty, full, pop, push_req, push_ok, ovf_bit;
    logic [7:0]    status, drive_val;

    // Synchroniser is left free-running through reset so a phi2 high already in
    // progress when reset drops never looks like a fresh rise.
    always_ff @(posedge hsclk) begin
        s1 <= bbc_phi2;
        s2 <= s1;
        s3 <= s2;
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    always_ff @(posedge hsclk) begin
        if (reset)
            shadow <= 8'h00;
        else if (s1)
            shadow <= bbc_data_in;
    end

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign mbox_valid = ~empty;
    assign mbox_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
    assign pop        = mbox_valid & mbox_ready;
    assign push_req   = (state == WRWAIT) && fall && (lat_adr == MBOX_ADDR);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok    = push_req && (!full || pop);

`ifdef MBOX_OVERFLOW_FLAG_EN
    logic ovf;
    always_ff @(posedge hsclk) begin
        if (reset)
            ovf <= 1'b0;
        else if (push_req && full && !pop)
            ovf <= 1'b1;
        else if (state == DRIVE && fall && lat_adr == STAT_ADDR)
            ovf <= 1'b0;
    end
    assign ovf_bit = ovf;
`else
    assign ovf_bit = 1'b0;
`endif

    assign status    = {5'b00000, ovf_bit, full, empty};
    assign drive_val = (lat_adr == MBOX_ADDR) ? reply_data : status;

    always_ff @(posedge hsclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
        end
    end

    always_ff @(posedge hsclk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= shadow;
    end

    always_ff @(posedge hsclk) begin
        if (reset) begin
            state        <= IDLE;
            lat_adr      <= 16'h0000;
            lat_rnw      <= 1'b1;
            hold_cnt     <= 3'd0;
            bbc_data_oe  <= 1'b0;
            bbc_data_out <= 8'h00;
            romsel       <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        lat_adr <= bbc_adr;
                        lat_rnw <= bbc_rnw;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (lat_rnw && (lat_adr == MBOX_ADDR || lat_adr == STAT_ADDR)) begin
                        state        <= DRIVE;
                        bbc_data_oe  <= 1'b1;
                        bbc_data_out <= drive_val;
                    end else if (!lat_rnw && (lat_adr == ROMSEL_ADDR || lat_adr == MBOX_ADDR)) begin
                        state <= WRWAIT;
                    end else begin
                        state <= SKIP;
                    end
                end
                DRIVE: begin
                    bbc_data_out <= drive_val;
                    if (fall) begin
                        state    <= HOLD;
                        hold_cnt <= 3'd0;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state       <= IDLE;
                        bbc_data_oe <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 3'd1;
                    end
                end
                WRWAIT: begin
                    if (fall) begin
                        if (lat_adr == ROMSEL_ADDR)
                            romsel <= shadow[3:0];
                        state <= IDLE;
                    end
                end
                SKIP: begin
                    if (fall)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bbc_bus_responder.sv
// tb_bbc_bus_responder: drives 6502-style bus cycles into bbc_bus_responder and
// compares against a queue-based model of the ROM select shadow and mailbox.
module tb_bbc_bus_responder;
    localparam int          FIFO_DEPTH  = 4;
    localparam int          HOLD_CYCLES = 2;
    localparam int          CYC         = 16;
    localparam int          HI          = 8;
    localparam int          DETECT      = 3;
    localparam logic [15:0] ROMSEL_ADDR = 16'hFE30;
    localparam logic [15:0] MBOX_ADDR   = 16'hFC40;
    localparam logic [15:0] STAT_ADDR   = 16'hFC41;

    logic        hsclk;
    logic        reset;
    logic        bbc_phi2;
    logic [15:0] bbc_adr;
    logic        bbc_rnw;
    logic [7:0]  bbc_data_in;
    logic [7:0]  bbc_data_out;
    logic        bbc_data_oe;
    logic [3:0]  romsel;
    logic        mbox_valid;
    logic [7:0]  mbox_data;
    logic        mbox_ready;
    logic [7:0]  reply_data;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_q[$];
    logic [3:0]  ref_romsel;
    logic        ref_ovf;

    logic [15:0] oe_obs;
    logic [7:0]  dout_tr  [CYC];
    logic [3:0]  romsel_tr[CYC];
    logic        valid_tr [CYC];
    logic [7:0]  mdata_tr [CYC];

    bbc_bus_responder #(
        .ROMSEL_ADDR (ROMSEL_ADDR),
        .MBOX_ADDR   (MBOX_ADDR),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .hsclk        (hsclk),
        .reset        (reset),
        .bbc_phi2     (bbc_phi2),
        .bbc_adr      (bbc_adr),
        .bbc_rnw      (bbc_rnw),
        .bbc_data_in  (bbc_data_in),
        .bbc_data_out (bbc_data_out),
        .bbc_data_oe  (bbc_data_oe),
        .romsel       (romsel),
        .mbox_valid   (mbox_valid),
        .mbox_data    (mbox_data),
        .mbox_ready   (mbox_ready),
        .reply_data   (reply_data)
    );

    initial hsclk = 1'b0;
    always #5 hsclk = ~hsclk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] ref_status();
        logic [7:0] s;
        s    = 8'h00;
        s[0] = (ref_q.size() == 0);
        s[1] = (ref_q.size() == FIFO_DEPTH);
`ifdef MBOX_OVERFLOW_FLAG_EN
        s[2] = ref_ovf;
`endif
        return s;
    endfunction

    // oe window in hsclk steps after phi2 rise: 3 to detect, DECODE, then DRIVE
    // until fall is detected, plus HOLD_CYCLES.
    function automatic logic [15:0] ref_oe_window(input logic [15:0] adr, input logic rnw);
        logic [15:0] w;
        w = '0;
        if (rnw && (adr == MBOX_ADDR || adr == STAT_ADDR))
            for (int i = 0; i < CYC; i++)
                if (i >= DETECT + 1 && i < HI + DETECT + HOLD_CYCLES)
                    w[i] = 1'b1;
        return w;
    endfunction

    task automatic ref_reset();
        ref_q.delete();
        ref_romsel = 4'h0;
        ref_ovf    = 1'b0;
    endtask

    task automatic ref_commit(input logic [15:0] adr, input logic rnw, input logic [7:0] wdata,
                              input logic pop_at_commit);
        if (pop_at_commit && ref_q.size() > 0)
            ref_q.delete(0);
        if (!rnw && adr == ROMSEL_ADDR)
            ref_romsel = wdata[3:0];
        if (!rnw && adr == MBOX_ADDR) begin
            if (ref_q.size() < FIFO_DEPTH)
                ref_q.push_back(wdata);
            else
                ref_ovf = 1'b1;
        end
        if (rnw && adr == STAT_ADDR)
            ref_ovf = 1'b0;
    endtask

    task automatic bus_cycle(input logic [15:0] adr, input logic rnw, input logic [7:0] wdata,
                             input logic [7:0] reply, input logic pop_at_commit);
        bbc_adr     = adr;
        bbc_rnw     = rnw;
        bbc_data_in = rnw ? 8'($urandom) : wdata;
        reply_data  = reply;
        oe_obs      = '0;
        for (int i = 0; i < CYC; i++) begin
            @(negedge hsclk);
            oe_obs[i]    = bbc_data_oe;
            dout_tr[i]   = bbc_data_out;
            romsel_tr[i] = romsel;
            valid_tr[i]  = mbox_valid;
            mdata_tr[i]  = mbox_data;
            if (i == 0)
                bbc_phi2 = 1'b1;
            if (i == HI)
                bbc_phi2 = 1'b0;
            mbox_ready = pop_at_commit && (i == HI + DETECT - 1);
        end
    endtask

    task automatic pop_one(output logic was_valid, output logic [7:0] data);
        @(negedge hsclk);
        was_valid  = mbox_valid;
        data       = mbox_data;
        mbox_ready = 1'b1;
        @(negedge hsclk);
        mbox_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge hsclk);
        reset = 1'b0;
        ref_reset();
        @(negedge hsclk);
        checks++;
        if (bbc_data_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_oe: got %b expected 0", bbc_data_oe); end
        checks++;
        if (bbc_data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout: got %h expected 00", bbc_data_out); end
        checks++;
        if (romsel !== 4'h0) begin errors++; $display("[TB] FAIL reset_romsel: got %h expected 0", romsel); end
        checks++;
        if (mbox_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", mbox_valid); end
        checks++;
        if (mbox_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_mdata: got %h expected 00", mbox_data); end
    endtask

    task automatic test_romsel();
        logic [3:0] old;
        old = ref_romsel;
        bus_cycle(ROMSEL_ADDR, 1'b0, 8'hAF, 8'h00, 1'b0);
        ref_commit(ROMSEL_ADDR, 1'b0, 8'hAF, 1'b0);
        checks++;
        if (romsel_tr[HI+DETECT-1] !== old) begin errors++; $display("[TB] FAIL romsel_early: got %h expected %h", romsel_tr[HI+DETECT-1], old); end
        checks++;
        if (romsel_tr[HI+DETECT] !== ref_romsel) begin errors++; $display("[TB] FAIL romsel_commit: got %h expected %h", romsel_tr[HI+DETECT], ref_romsel); end
        checks++;
        if (oe_obs !== 16'h0) begin errors++; $display("[TB] FAIL romsel_write_oe: got %h expected 0000", oe_obs); end
        bus_cycle(ROMSEL_ADDR, 1'b1, 8'h00, 8'h77, 1'b0);
        ref_commit(ROMSEL_ADDR, 1'b1, 8'h00, 1'b0);
        checks++;
        if (oe_obs !== 16'h0) begin errors++; $display("[TB] FAIL romsel_read_oe: got %h expected 0000", oe_obs); end
        checks++;
        if (romsel_tr[CYC-1] !== ref_romsel) begin errors++; $display("[TB] FAIL romsel_after_read: got %h expected %h", romsel_tr[CYC-1], ref_romsel); end
    endtask

    task automatic test_mailbox_fill();
        logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [7:0] exp;
        logic       v;
        logic [7:0] d;
        for (int k = 0; k < 5; k++) begin
            bus_cycle(MBOX_ADDR, 1'b0, bytes[k], 8'h00, 1'b0);
            if (k == 0) begin
                checks++;
                if (valid_tr[HI+DETECT-1] !== 1'b0) begin errors++; $display("[TB] FAIL fill_valid_early: got %b expected 0", valid_tr[HI+DETECT-1]); end
                checks++;
                if (valid_tr[HI+DETECT] !== 1'b1) begin errors++; $display("[TB] FAIL fill_valid_commit: got %b expected 1", valid_tr[HI+DETECT]); end
            end
            ref_commit(MBOX_ADDR, 1'b0, bytes[k], 1'b0);
            checks++;
            if (mdata_tr[CYC-1] !== ref_q[0]) begin errors++; $display("[TB] FAIL fill_head: got %h expected %h", mdata_tr[CYC-1], ref_q[0]); end
        end
        exp = ref_status();
        bus_cycle(STAT_ADDR, 1'b1, 8'h00, 8'h00, 1'b0);
        ref_commit(STAT_ADDR, 1'b1, 8'h00, 1'b0);
        checks++;
        if (dout_tr[HI+1] !== exp) begin errors++; $display("[TB] FAIL fill_status: got %h expected %h", dout_tr[HI+1], exp); end
        for (int k = 0; k < 4; k++) begin
            pop_one(v, d);
            checks++;
            if (v !== 1'b1 || d !== ref_q[0]) begin errors++; $display("[TB] FAIL fill_pop: got %b/%h expected 1/%h", v, d, ref_q[0]); end
            ref_q.delete(0);
        end
        @(negedge hsclk);
        checks++;
        if (mbox_valid !== 1'b0) begin errors++; $display("[TB] FAIL fill_drained: got %b expected 0", mbox_valid); end
        exp = ref_status();
        bus_cycle(STAT_ADDR, 1'b1, 8'h00, 8'h00, 1'b0);
        ref_commit(STAT_ADDR, 1'b1, 8'h00, 1'b0);
        checks++;
        if (dout_tr[HI+1] !== exp) begin errors++; $display("[TB] FAIL ovf_cleared_status: got %h expected %h", dout_tr[HI+1], exp); end
    endtask

    task automatic test_read_reply();
        logic [15:0] w;
        w = ref_oe_window(MBOX_ADDR, 1'b1);
        bus_cycle(MBOX_ADDR, 1'b1, 8'h00, 8'h5A, 1'b0);
        ref_commit(MBOX_ADDR, 1'b1, 8'h00, 1'b0);
        checks++;
        if (oe_obs !== w) begin errors++; $display("[TB] FAIL reply_oe_window: got %h expected %h", oe_obs, w); end
        checks++;
        if (dout_tr[HI+1] !== 8'h5A) begin errors++; $display("[TB] FAIL reply_data: got %h expected 5a", dout_tr[HI+1]); end
        checks++;
        if (dout_tr[HI+DETECT+HOLD_CYCLES-1] !== 8'h5A) begin errors++; $display("[TB] FAIL reply_hold_data: got %h expected 5a", dout_tr[HI+DETECT+HOLD_CYCLES-1]); end
    endtask

    task automatic test_ignored();
        bus_cycle(16'h8000, 1'b1, 8'h00, 8'h99, 1'b0);
        ref_commit(16'h8000, 1'b1, 8'h00, 1'b0);
        checks++;
        if (oe_obs !== 16'h0) begin errors++; $display("[TB] FAIL dummy_oe: got %h expected 0000", oe_obs); end
        bus_cycle(STAT_ADDR, 1'b0, 8'hFE, 8'h00, 1'b0);
        ref_commit(STAT_ADDR, 1'b0, 8'hFE, 1'b0);
        checks++;
        if (oe_obs !== 16'h0) begin errors++; $display("[TB] FAIL statwr_oe: got %h expected 0000", oe_obs); end
        checks++;
        if (valid_tr[CYC-1] !== (ref_q.size() > 0)) begin errors++; $display("[TB] FAIL statwr_valid: got %b expected %b", valid_tr[CYC-1], ref_q.size() > 0); end
        checks++;
        if (romsel_tr[CYC-1] !== ref_romsel) begin errors++; $display("[TB] FAIL statwr_romsel: got %h expected %h", romsel_tr[CYC-1], ref_romsel); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] head;
        logic [7:0] exp;
        logic       v;
        logic [7:0] d;
        while (ref_q.size() < FIFO_DEPTH) begin
            d = 8'($urandom);
            bus_cycle(MBOX_ADDR, 1'b0, d, 8'h00, 1'b0);
            ref_commit(MBOX_ADDR, 1'b0, d, 1'b0);
        end
        head = ref_q[0];
        bus_cycle(MBOX_ADDR, 1'b0, 8'hC3, 8'h00, 1'b1);
        ref_commit(MBOX_ADDR, 1'b0, 8'hC3, 1'b1);
        checks++;
        if (mdata_tr[HI+DETECT-1] !== head) begin errors++; $display("[TB] FAIL fullpp_popped: got %h expected %h", mdata_tr[HI+DETECT-1], head); end
        exp = ref_status();
        bus_cycle(STAT_ADDR, 1'b1, 8'h00, 8'h00, 1'b0);
        ref_commit(STAT_ADDR, 1'b1, 8'h00, 1'b0);
        checks++;
        if (dout_tr[HI+1] !== exp) begin errors++; $display("[TB] FAIL fullpp_status: got %h expected %h", dout_tr[HI+1], exp); end
        while (ref_q.size() > 0) begin
            pop_one(v, d);
            checks++;
            if (v !== 1'b1 || d !== ref_q[0]) begin errors++; $display("[TB] FAIL fullpp_pop: got %b/%h expected 1/%h", v, d, ref_q[0]); end
            ref_q.delete(0);
        end
    endtask

    task automatic test_back_to_back();
        bus_cycle(MBOX_ADDR, 1'b0, 8'h3C, 8'h00, 1'b1);
        ref_commit(MBOX_ADDR, 1'b0, 8'h3C, 1'b1);
        checks++;
        if (valid_tr[CYC-1] !== 1'b1 || mdata_tr[CYC-1] !== ref_q[0]) begin errors++; $display("[TB] FAIL emptypp_push: got %b/%h expected 1/%h", valid_tr[CYC-1], mdata_tr[CYC-1], ref_q[0]); end
        bus_cycle(ROMSEL_ADDR, 1'b0, 8'h09, 8'h00, 1'b0);
        ref_commit(ROMSEL_ADDR, 1'b0, 8'h09, 1'b0);
        checks++;
        if (romsel_tr[CYC-1] !== ref_romsel) begin errors++; $display("[TB] FAIL b2b_romsel: got %h expected %h", romsel_tr[CYC-1], ref_romsel); end
    endtask

    task automatic test_reset_mid_drive();
        logic       late_oe;
        logic [7:0] exp;
        late_oe    = 1'b0;
        bbc_adr    = MBOX_ADDR;
        bbc_rnw    = 1'b1;
        reply_data = 8'hE7;
        for (int i = 0; i < CYC; i++) begin
            @(negedge hsclk);
            if (i == DETECT + 2) begin
                checks++;
                if (bbc_data_oe !== 1'b1) begin errors++; $display("[TB] FAIL middrive_oe_before: got %b expected 1", bbc_data_oe); end
            end
            if (i == DETECT + 3) begin
                checks++;
                if (bbc_data_oe !== 1'b0) begin errors++; $display("[TB] FAIL middrive_oe_after: got %b expected 0", bbc_data_oe); end
                checks++;
                if (mbox_valid !== 1'b0 || romsel !== 4'h0) begin errors++; $display("[TB] FAIL middrive_state: got %b/%h expected 0/0", mbox_valid, romsel); end
            end
            if (i > DETECT + 3)
                late_oe = late_oe | bbc_data_oe;
            if (i == 0)
                bbc_phi2 = 1'b1;
            if (i == DETECT + 2)
                reset = 1'b1;
            if (i == DETECT + 3)
                reset = 1'b0;
            if (i == HI)
                bbc_phi2 = 1'b0;
        end
        ref_reset();
        checks++;
        if (late_oe !== 1'b0) begin errors++; $display("[TB] FAIL middrive_serviced: got %b expected 0", late_oe); end
        exp = ref_status();
        bus_cycle(STAT_ADDR, 1'b1, 8'h00, 8'h00, 1'b0);
        ref_commit(STAT_ADDR, 1'b1, 8'h00, 1'b0);
        checks++;
        if (dout_tr[HI+1] !== exp) begin errors++; $display("[TB] FAIL postreset_status: got %h expected %h", dout_tr[HI+1], exp); end
    endtask

    task automatic test_random();
        logic [15:0] addrs [4] = '{ROMSEL_ADDR, MBOX_ADDR, STAT_ADDR, 16'h8000};
        logic [15:0] adr, w;
        logic        rnw, pac, hv, v;
        logic [7:0]  wdata, reply, exp_stat, head, d, exp_d;
        for (int n = 0; n < 60; n++) begin
            adr      = ($urandom_range(0, 9) >= 8) ? 16'($urandom) : addrs[$urandom_range(0, 3)];
            rnw      = 1'($urandom_range(0, 1));
            wdata    = 8'($urandom);
            reply    = 8'($urandom);
            pac      = ($urandom_range(0, 3) == 0);
            w        = ref_oe_window(adr, rnw);
            exp_stat = ref_status();
            hv       = (ref_q.size() > 0);
            head     = hv ? ref_q[0] : 8'h00;
            bus_cycle(adr, rnw, wdata, reply, pac);
            checks++;
            if (oe_obs !== w) begin errors++; $display("[TB] FAIL rand_oe: adr %h rnw %b got %h expected %h", adr, rnw, oe_obs, w); end
            if (w != 16'h0) begin
                exp_d = (adr == MBOX_ADDR) ? reply : exp_stat;
                checks++;
                if (dout_tr[HI+1] !== exp_d) begin errors++; $display("[TB] FAIL rand_rdata: adr %h got %h expected %h", adr, dout_tr[HI+1], exp_d); end
            end
            if (pac && hv) begin
                checks++;
                if (mdata_tr[HI+DETECT-1] !== head) begin errors++; $display("[TB] FAIL rand_commit_pop: got %h expected %h", mdata_tr[HI+DETECT-1], head); end
            end
            ref_commit(adr, rnw, wdata, pac);
            exp_d = (ref_q.size() > 0) ? ref_q[0] : 8'h00;
            checks++;
            if (romsel_tr[CYC-1] !== ref_romsel) begin errors++; $display("[TB] FAIL rand_romsel: got %h expected %h", romsel_tr[CYC-1], ref_romsel); end
            checks++;
            if (valid_tr[CYC-1] !== (ref_q.size() > 0) || mdata_tr[CYC-1] !== exp_d) begin errors++; $display("[TB] FAIL rand_fifo: got %b/%h expected %b/%h", valid_tr[CYC-1], mdata_tr[CYC-1], ref_q.size() > 0, exp_d); end
            if ($urandom_range(0, 2) == 0) begin
                hv    = (ref_q.size() > 0);
                exp_d = hv ? ref_q[0] : 8'h00;
                pop_one(v, d);
                checks++;
                if (v !== hv || d !== exp_d) begin errors++; $display("[TB] FAIL rand_pop: got %b/%h expected %b/%h", v, d, hv, exp_d); end
                if (hv)
                    ref_q.delete(0);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        bbc_phi2    = 1'b0;
        bbc_adr     = 16'h0000;
        bbc_rnw     = 1'b1;
        bbc_data_in = 8'h00;
        mbox_ready  = 1'b0;
        reply_data  = 8'h00;
        ref_reset();
        test_reset();
        test_romsel();
        test_mailbox_fill();
        test_read_reply();
        test_ignored();
        test_full_push_pop();
        test_back_to_back();
        test_reset_mid_drive();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
